dbg_step_ctrl: RTL and testbench



---
 rtl/dbg_step_ctrl.sv | 129 ++++++++++++
 tb/tb_dbg_step_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_step_ctrl.sv
// Pushbutton run/pause/single-step controller for the CPU clock enable.
// Synchronises and debounces the raw button, classifies presses, drives cpu_ce.
module dbg_step_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES   = 65535,
  parameter int unsigned LONG_PRESS_CYCLES = 4000000,
  parameter bit          START_RUNNING     = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_n,
  input  logic        cpu_halted,
  input  logic        instr_retired,
  output logic        cpu_ce,
  output logic [1:0]  mode,
  output logic [15:0] step_count,
  output logic        btn_level
);

  localparam int unsigned DebW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HoldW = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_PRESS_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldMax  = HoldW'(LONG_PRESS_CYCLES);

  typedef enum logic [1:0] {
    StPaused = 2'b00,
    StRun    = 2'b01,
    StStep   = 2'b10
  } state_e;

  localparam state_e ResetState = START_RUNNING ? StRun : StPaused;

  logic [1:0]       sync_q;
  logic             pressed_sync;
  logic [DebW-1:0]  deb_cnt_q;
  logic             btn_level_q;
  logic             btn_prev_q;
  logic [HoldW-1:0] hold_cnt_q;
  logic             long_evt;
  logic             short_evt;
  state_e           state_q;
  logic [15:0]      step_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], btn_n};
    end
  end

  assign pressed_sync = ~sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt_q   <= '0;
      btn_level_q <= 1'b0;
    end else if (pressed_sync == btn_level_q) begin
      deb_cnt_q <= '0;
    end else if (deb_cnt_q == DebLast) begin
      deb_cnt_q   <= '0;
      btn_level_q <= ~btn_level_q;
    end else begin
      deb_cnt_q <= deb_cnt_q + DebW'(1);
    end
  end

  // Holding the counter at zero while released is equivalent to clearing it on
  // the rising edge; saturation at HoldMax marks a press whose long event fired.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_prev_q <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      btn_prev_q <= btn_level_q;
      if (!btn_level_q) begin
        hold_cnt_q <= '0;
      end else if (hold_cnt_q != HoldMax) begin
        hold_cnt_q <= hold_cnt_q + HoldW'(1);
      end
    end
  end

  assign long_evt  = btn_level_q && (hold_cnt_q == HoldLast);
  assign short_evt = btn_prev_q && !btn_level_q && (hold_cnt_q != HoldMax);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ResetState;
    end else begin
      unique case (state_q)
        StPaused: begin
          if (long_evt) begin
            state_q <= StRun;
          end else if (short_evt) begin
            state_q <= StStep;
          end
        end
        StRun: begin
          if (long_evt || cpu_halted) begin
            state_q <= StPaused;
          end
        end
        StStep: begin
          if (instr_retired || long_evt || cpu_halted) begin
            state_q <= StPaused;
          end
        end
        default: state_q <= StPaused;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt_q <= '0;
    end else if (instr_retired && cpu_ce) begin
      step_cnt_q <= step_cnt_q + 16'd1;
    end
  end

  // Combinational so the enable drops in the cycle right after the retire pulse.
  assign cpu_ce     = (state_q == StRun) || (state_q == StStep);
  assign mode       = state_q;
  assign step_count = step_cnt_q;
  assign btn_level  = btn_level_q;

endmodule

// File: tb/tb_dbg_step_ctrl.sv
// Directed bench for dbg_step_ctrl with short debounce and long-press thresholds.
module tb_dbg_step_ctrl;

  logic        clk;
  logic        rst_n;
  logic        btn_n;
  logic        cpu_halted;
  logic        instr_retired;
  logic        cpu_ce;
  logic [1:0]  mode;
  logic [15:0] step_count;
  logic        btn_level;

  int checks;
  int failures;

  dbg_step_ctrl #(
    .DEBOUNCE_CYCLES  (4),
    .LONG_PRESS_CYCLES(20),
    .START_RUNNING    (1'b0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_n        (btn_n),
    .cpu_halted   (cpu_halted),
    .instr_retired(instr_retired),
    .cpu_ce       (cpu_ce),
    .mode         (mode),
    .step_count   (step_count),
    .btn_level    (btn_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int n);
    btn_n = 1'b0;
    repeat (n) tick();
    btn_n = 1'b1;
  endtask

  task automatic wait_step(input string name);
    int n;
    n = 0;
    while (mode != 2'b10 && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (mode !== 2'b10) begin
      failures++;
      $display("FAIL %s got mode=%b exp=10", name, mode);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    btn_n = 1'b1;
    cpu_halted = 1'b0;
    instr_retired = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (mode !== 2'b00) begin
      failures++; $display("FAIL reset_mode got=%b exp=00", mode);
    end
    checks++;
    if (cpu_ce !== 1'b0) begin
      failures++; $display("FAIL reset_cpu_ce got=%b exp=0", cpu_ce);
    end
    checks++;
    if (step_count !== 16'h0000) begin
      failures++; $display("FAIL reset_step_count got=%h exp=0000", step_count);
    end
    checks++;
    if (btn_level !== 1'b0) begin
      failures++; $display("FAIL reset_btn_level got=%b exp=0", btn_level);
    end
  endtask

  task automatic test_bounce();
    logic saw_high;
    int   pat_len[4];
    logic pat_val[4];
    saw_high = 1'b0;
    pat_len = '{3, 2, 3, 8};
    pat_val = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int p = 0; p < 4; p++) begin
      btn_n = pat_val[p];
      for (int i = 0; i < pat_len[p]; i++) begin
        tick();
        if (btn_level) saw_high = 1'b1;
      end
    end
    checks++;
    if (saw_high !== 1'b0) begin
      failures++; $display("FAIL bounce_glitch got=%b exp=0", saw_high);
    end
    btn_n = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 5) begin
        checks++;
        if (btn_level !== 1'b0) begin
          failures++; $display("FAIL debounce_early got=%b exp=0", btn_level);
        end
      end
      if (i == 6) begin
        checks++;
        if (btn_level !== 1'b1) begin
          failures++; $display("FAIL debounce_edge got=%b exp=1", btn_level);
        end
      end
    end
    btn_n = 1'b1;
    repeat (12) tick();
    checks++;
    if (mode !== 2'b10) begin
      failures++; $display("FAIL bounce_short_step got=%b exp=10", mode);
    end
    cpu_halted = 1'b1;
    tick();
    cpu_halted = 1'b0;
    checks++;
    if (mode !== 2'b00) begin
      failures++; $display("FAIL step_halt_exit got=%b exp=00", mode);
    end
  endtask

  task automatic test_short_step();
    int ce_cycles;
    ce_cycles = 0;
    press(8);
    wait_step("short_enter_step");
    for (int i = 0; i < 20; i++) begin
      if (cpu_ce) begin
        ce_cycles++;
        instr_retired = (ce_cycles == 5);
      end else begin
        instr_retired = 1'b0;
      end
      tick();
    end
    instr_retired = 1'b0;
    checks++;
    if (ce_cycles != 5) begin
      failures++; $display("FAIL step_ce_cycles got=%0d exp=5", ce_cycles);
    end
    checks++;
    if (mode !== 2'b00) begin
      failures++; $display("FAIL step_done_mode got=%b exp=00", mode);
    end
    checks++;
    if (step_count !== 16'h0001) begin
      failures++; $display("FAIL step_count_one got=%h exp=0001", step_count);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    press(8);
    wait_step("mid_enter_step");
    btn_n = 1'b0;
    n = 0;
    while (!btn_level && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (btn_level !== 1'b1) begin
      failures++; $display("FAIL mid_press_level got=%b exp=1", btn_level);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (mode !== 2'b00) begin
      failures++; $display("FAIL async_reset_mode got=%b exp=00", mode);
    end
    checks++;
    if (step_count !== 16'h0000) begin
      failures++; $display("FAIL async_reset_count got=%h exp=0000", step_count);
    end
    checks++;
    if (btn_level !== 1'b0 || cpu_ce !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_level_ce got=%b%b exp=00", btn_level, cpu_ce);
    end
    btn_n = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (30) tick();
    checks++;
    if (mode !== 2'b00 || btn_level !== 1'b0) begin
      failures++;
      $display("FAIL reset_discard_press got mode=%b level=%b exp mode=00 level=0",
               mode, btn_level);
    end
  endtask

  task automatic test_long_press();
    int n;
    btn_n = 1'b0;
    n = 0;
    while (!btn_level && n < 20) begin
      tick();
      n++;
    end
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 19) begin
        checks++;
        if (mode !== 2'b00) begin
          failures++; $display("FAIL long_early got=%b exp=00", mode);
        end
      end
      if (i == 20) begin
        checks++;
        if (mode !== 2'b01) begin
          failures++; $display("FAIL long_to_run got=%b exp=01", mode);
        end
      end
    end
    repeat (10) tick();
    btn_n = 1'b1;
    repeat (15) tick();
    checks++;
    if (mode !== 2'b01 || btn_level !== 1'b0) begin
      failures++;
      $display("FAIL long_release got mode=%b level=%b exp mode=01 level=0", mode, btn_level);
    end
    press(40);
    repeat (15) tick();
    checks++;
    if (mode !== 2'b00) begin
      failures++; $display("FAIL long_to_paused got=%b exp=00", mode);
    end
  endtask

  task automatic test_halt();
    int n;
    press(40);
    repeat (15) tick();
    checks++;
    if (mode !== 2'b01) begin
      failures++; $display("FAIL halt_setup_run got=%b exp=01", mode);
    end
    cpu_halted = 1'b1;
    tick();
    checks++;
    if (mode !== 2'b00) begin
      failures++; $display("FAIL run_halt got=%b exp=00", mode);
    end
    press(8);
    wait_step("halted_short_step");
    tick();
    checks++;
    if (mode !== 2'b00) begin
      failures++; $display("FAIL halted_step_exit got=%b exp=00", mode);
    end
    cpu_halted = 1'b0;
    press(8);
    wait_step("abort_enter_step");
    btn_n = 1'b0;
    n = 0;
    while (!btn_level && n < 20) begin
      tick();
      n++;
    end
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 19) begin
        checks++;
        if (mode !== 2'b10) begin
          failures++; $display("FAIL abort_early got=%b exp=10", mode);
        end
      end
      if (i == 20) begin
        checks++;
        if (mode !== 2'b00) begin
          failures++; $display("FAIL long_abort_step got=%b exp=00", mode);
        end
      end
    end
    btn_n = 1'b1;
    repeat (15) tick();
  endtask

  task automatic test_wrap();
    press(40);
    repeat (15) tick();
    instr_retired = 1'b1;
    repeat (65535) tick();
    instr_retired = 1'b0;
    checks++;
    if (step_count !== 16'hFFFF) begin
      failures++; $display("FAIL count_preload got=%h exp=ffff", step_count);
    end
    instr_retired = 1'b1;
    tick();
    instr_retired = 1'b0;
    checks++;
    if (step_count !== 16'h0000) begin
      failures++; $display("FAIL count_wrap got=%h exp=0000", step_count);
    end
    cpu_halted = 1'b1;
    tick();
    cpu_halted = 1'b0;
    instr_retired = 1'b1;
    tick();
    instr_retired = 1'b0;
    tick();
    checks++;
    if (step_count !== 16'h0000 || mode !== 2'b00) begin
      failures++;
      $display("FAIL paused_retire got count=%h mode=%b exp count=0000 mode=00",
               step_count, mode);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_bounce();
    test_short_step();
    test_reset_mid();
    test_long_press();
    test_halt();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
